// File: rtl/mc_stall_ctrl_if.sv
// Decode/execute-unit handshake bundle for the multi-cycle stall scheduler.
// The master drives requests and unit status, and the slave returns the stall and start controls.
interface mc_stall_ctrl_if;
    logic       mc_req_i;
    logic [1:0] mc_unit_i;
    logic [2:0] unit_done_i;
    logic       brj_i;
    logic       load_use_i;
    logic [2:0] unit_start_o;
    logic       stall_o;
    logic       stall_general_o;
    logic       result_we_o;
    logic       busy_o;
    logic       timeout_o;
    logic       err_o;

    modport master (
        output mc_req_i, mc_unit_i, unit_done_i, brj_i, load_use_i,
        input  unit_start_o, stall_o, stall_general_o, result_we_o, busy_o, timeout_o, err_o
    );

    modport slave (
        input  mc_req_i, mc_unit_i, unit_done_i, brj_i, load_use_i,
        output unit_start_o, stall_o, stall_general_o, result_we_o, busy_o, timeout_o, err_o
    );
endinterface

// File: rtl/mc_stall_ctrl.sv
// Multi-cycle issue scheduler: starts mul/div/fpu and freezes the pipeline until done or timeout.
// It releases the pipeline for one writeback cycle and gates the single-cycle load-use stall.
module mc_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [1:0]           r_unit;
    logic                 r_timeout;
    logic                 r_err;
    logic [2:0]           w_unit_onehot;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_done;
    logic                 w_timeout_hit;

    // Load-use and a flushing branch both block acceptance; the request simply retries later.
    always_comb begin
        w_unit_onehot = 3'(1) << r_unit;
        w_accept      = (r_state == S_IDLE) && bus.mc_req_i && !bus.brj_i && !bus.load_use_i;
        w_illegal     = w_accept && (bus.mc_unit_i == 2'd3);
        w_done        = (bus.unit_done_i & w_unit_onehot) != 3'b000;
        w_timeout_hit = (r_state == S_WAIT) && !w_done && (r_cnt == LP_CNT_LAST);
    end

    // NOTE: state and datapath flops use <= so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: assigning the default first keeps this comb block from inferring a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept && !w_illegal) w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT:  if (w_done || w_timeout_hit) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_unit    <= 2'd0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept && !w_illegal) r_unit <= bus.mc_unit_i;
            if (r_state == S_START)     r_cnt  <= '0;
            else if (r_state == S_WAIT) r_cnt  <= r_cnt + 1'b1;
            r_timeout <= w_timeout_hit;
            r_err     <= r_err | w_illegal | w_timeout_hit;
        end
    end

    always_comb begin
        bus.unit_start_o    = (r_state == S_START) ? w_unit_onehot : 3'b000;
        bus.stall_general_o = (r_state == S_START) || (r_state == S_WAIT);
        bus.result_we_o     = (r_state == S_DRAIN);
        bus.busy_o          = (r_state != S_IDLE);
        bus.timeout_o       = r_timeout;
        bus.err_o           = r_err;
        bus.stall_o         = bus.load_use_i && (r_state == S_IDLE) && !bus.brj_i;
    end
endmodule

// File: tb/tb_mc_stall_ctrl.sv
// Scenario checks plus a randomized run against a cycle-age reference model of the stall scheduler.
module tb_mc_stall_ctrl;
    localparam int T = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mc_stall_ctrl_if bus ();

    mc_stall_ctrl #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Output snapshot: {unit_start[2:0], stall, stall_general, result_we, busy, timeout, err}
    function automatic logic [8:0] outs();
        return {bus.unit_start_o, bus.stall_o, bus.stall_general_o, bus.result_we_o,
                bus.busy_o, bus.timeout_o, bus.err_o};
    endfunction

    task automatic drive_idle();
        bus.mc_req_i    = 1'b0;
        bus.mc_unit_i   = 2'd0;
        bus.unit_done_i = 3'b000;
        bus.brj_i       = 1'b0;
        bus.load_use_i  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        #2;
        n_total++; if (outs() !== 9'h000) $display("FAIL reset_hold: got %b want %b", outs(), 9'h000); else n_pass++;
        do_reset();
        @(negedge clk);
        n_total++; if (outs() !== 9'h000) $display("FAIL reset_release: got %b want %b", outs(), 9'h000); else n_pass++;
        next_cycle();
    endtask

    task automatic test_div_done();
        int         sg_cnt;
        logic [2:0] start_extra;
        do_reset();
        bus.mc_req_i  = 1'b1;
        bus.mc_unit_i = 2'd1;
        next_cycle();
        @(negedge clk);
        n_total++; if (bus.unit_start_o !== 3'b010) $display("FAIL div_start: got %b want 010", bus.unit_start_o); else n_pass++;
        sg_cnt      = int'(bus.stall_general_o);
        start_extra = 3'b000;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 5) bus.unit_done_i = 3'b010;
            @(negedge clk);
            sg_cnt      += int'(bus.stall_general_o);
            start_extra |= bus.unit_start_o;
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_total++; if ({bus.result_we_o, bus.stall_general_o, bus.timeout_o} !== 3'b100)
            $display("FAIL div_drain: got we/sg/to=%b want 100", {bus.result_we_o, bus.stall_general_o, bus.timeout_o}); else n_pass++;
        n_total++; if (sg_cnt != 6) $display("FAIL div_stall_len: got %0d want 6", sg_cnt); else n_pass++;
        n_total++; if (start_extra !== 3'b000) $display("FAIL div_start_once: got %b want 000", start_extra); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if ({bus.busy_o, bus.result_we_o} !== 2'b00) $display("FAIL div_idle: got %b want 00", {bus.busy_o, bus.result_we_o}); else n_pass++;
    endtask

    task automatic test_flush_illegal();
        logic seen;
        do_reset();
        bus.mc_req_i   = 1'b1;
        bus.mc_unit_i  = 2'd0;
        bus.brj_i      = 1'b1;
        bus.load_use_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen |= bus.busy_o | bus.stall_o | (bus.unit_start_o != 3'b000);
            next_cycle();
        end
        n_total++; if (seen !== 1'b0) $display("FAIL flush_drop: got activity=%b want 0", seen); else n_pass++;
        bus.brj_i      = 1'b0;
        bus.load_use_i = 1'b0;
        bus.mc_unit_i  = 2'd3;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_total++; if ({bus.err_o, bus.busy_o, bus.unit_start_o} !== 5'b10000)
            $display("FAIL illegal_unit: got err/busy/start=%b want 10000", {bus.err_o, bus.busy_o, bus.unit_start_o}); else n_pass++;
        repeat (3) next_cycle();
        @(negedge clk);
        n_total++; if (bus.err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.err_o); else n_pass++;
    endtask

    task automatic test_timeout(input bit with_done);
        int   sg_cnt;
        int   n;
        logic to_early;
        logic released;
        do_reset();
        bus.mc_req_i  = 1'b1;
        bus.mc_unit_i = 2'd2;
        next_cycle();
        sg_cnt = 0; n = 0; to_early = 1'b0; released = 1'b0;
        while (n < 300) begin
            @(negedge clk);
            if (bus.result_we_o) begin
                released = 1'b1;
                break;
            end
            sg_cnt   += int'(bus.stall_general_o);
            to_early |= bus.timeout_o;
            n++;
            next_cycle();
            bus.unit_done_i = (with_done && n == T) ? 3'b100 : 3'b000;
        end
        drive_idle();
        n_total++; if (!released) $display("FAIL timeout_release_bound: got no release in 300 cycles want release"); else n_pass++;
        n_total++; if (sg_cnt != T + 1) $display("FAIL timeout_stall_len[%0d]: got %0d want %0d", with_done, sg_cnt, T + 1); else n_pass++;
        n_total++; if (to_early !== 1'b0) $display("FAIL timeout_early[%0d]: got %b want 0", with_done, to_early); else n_pass++;
        n_total++; if ({bus.timeout_o, bus.err_o} !== (with_done ? 2'b00 : 2'b11))
            $display("FAIL timeout_pulse[%0d]: got to/err=%b want %b", with_done, {bus.timeout_o, bus.err_o}, with_done ? 2'b00 : 2'b11); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if ({bus.timeout_o, bus.err_o, bus.busy_o} !== (with_done ? 3'b000 : 3'b010))
            $display("FAIL timeout_after[%0d]: got to/err/busy=%b want %b", with_done, {bus.timeout_o, bus.err_o, bus.busy_o}, with_done ? 3'b000 : 3'b010); else n_pass++;
    endtask

    task automatic test_wrong_done();
        do_reset();
        bus.mc_req_i  = 1'b1;
        bus.mc_unit_i = 2'd0;
        next_cycle();
        next_cycle();
        bus.unit_done_i = 3'b100;
        next_cycle();
        bus.unit_done_i = 3'b000;
        @(negedge clk);
        n_total++; if ({bus.stall_general_o, bus.result_we_o} !== 2'b10)
            $display("FAIL wrong_done_ignored: got sg/we=%b want 10", {bus.stall_general_o, bus.result_we_o}); else n_pass++;
        bus.unit_done_i = 3'b001;
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_total++; if ({bus.stall_general_o, bus.result_we_o} !== 2'b01)
            $display("FAIL right_done_drain: got sg/we=%b want 01", {bus.stall_general_o, bus.result_we_o}); else n_pass++;
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.mc_req_i   = 1'b1;
        bus.mc_unit_i  = 2'd0;
        bus.load_use_i = 1'b1;
        @(negedge clk);
        n_total++; if (bus.stall_o !== 1'b1) $display("FAIL load_use_stall: got %b want 1", bus.stall_o); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if ({bus.busy_o, bus.unit_start_o} !== 4'b0000)
            $display("FAIL load_use_blocks: got busy/start=%b want 0000", {bus.busy_o, bus.unit_start_o}); else n_pass++;
        bus.load_use_i = 1'b0;
        next_cycle();
        @(negedge clk);
        n_total++; if (bus.unit_start_o !== 3'b001) $display("FAIL load_use_retry: got %b want 001", bus.unit_start_o); else n_pass++;
        next_cycle();
        bus.load_use_i = 1'b1;
        @(negedge clk);
        n_total++; if ({bus.stall_o, bus.stall_general_o} !== 2'b01)
            $display("FAIL load_use_in_wait: got stall/sg=%b want 01", {bus.stall_o, bus.stall_general_o}); else n_pass++;
        bus.unit_done_i = 3'b001;
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        do_reset();
        bus.mc_req_i  = 1'b1;
        bus.mc_unit_i = 2'd1;
        next_cycle();
        repeat (11) next_cycle();
        @(negedge clk);
        n_total++; if (bus.stall_general_o !== 1'b1) $display("FAIL mid_wait_stalled: got %b want 1", bus.stall_general_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (outs() !== 9'h000) $display("FAIL mid_wait_reset: got %b want %b", outs(), 9'h000); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_idle();
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen |= bus.busy_o | bus.stall_general_o | (bus.unit_start_o != 3'b000);
            next_cycle();
        end
        n_total++; if (seen !== 1'b0) $display("FAIL mid_wait_after: got activity=%b want 0", seen); else n_pass++;
    endtask

    // The reference tracks an operation by its age in cycles since acceptance.
    // Age 1 is the start cycle, age k+1 is wait cycle k, and release lands one cycle after the deciding wait cycle.
    task automatic test_random();
        int         m_age, m_drain_at, wait_k;
        logic [1:0] m_unit;
        logic       m_err, m_timed_out, in_drain;
        logic [8:0] exp_v;
        do_reset();
        m_age = 0; m_drain_at = 0; m_unit = 2'd0; m_err = 1'b0; m_timed_out = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.mc_req_i    = $urandom_range(0, 1) == 1;
            bus.mc_unit_i   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.brj_i       = $urandom_range(0, 9) == 0;
            bus.load_use_i  = $urandom_range(0, 6) == 0;
            bus.unit_done_i = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            @(negedge clk);
            in_drain = (m_drain_at != 0) && (m_age == m_drain_at);
            exp_v = {(m_age == 1) ? (3'(1) << m_unit) : 3'b000,
                     bus.load_use_i && (m_age == 0) && !bus.brj_i,
                     (m_age >= 1) && !in_drain,
                     in_drain,
                     m_age != 0,
                     in_drain && m_timed_out,
                     m_err};
            n_total++; if (outs() !== exp_v) $display("FAIL random_cycle_%0d: got %b want %b", c, outs(), exp_v); else n_pass++;
            @(posedge clk);
            if (m_age == 0) begin
                if (bus.mc_req_i && !bus.brj_i && !bus.load_use_i) begin
                    if (bus.mc_unit_i == 2'd3) m_err = 1'b1;
                    else begin
                        m_age = 1; m_unit = bus.mc_unit_i; m_drain_at = 0; m_timed_out = 1'b0;
                    end
                end
            end else if (in_drain) begin
                m_age = 0;
            end else begin
                wait_k = m_age - 1;
                if (wait_k >= 1 && m_drain_at == 0) begin
                    if (bus.unit_done_i[m_unit]) m_drain_at = m_age + 1;
                    else if (wait_k == T) begin
                        m_drain_at = m_age + 1; m_timed_out = 1'b1; m_err = 1'b1;
                    end
                end
                m_age++;
            end
            #1;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_div_done();
        test_flush_illegal();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_wrong_done();
        test_load_use();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
